seg_scan_controller: RTL

- Time-multiplexes a four-digit BCD value onto the Basys3 four-anode 7-segment display.
- Drives one shared BCD nibble into the existing single-digit decoder (inputs w,x,y,z) and sequences the active-low anodes an0-an3.
- Adds anti-ghosting blank slots, optional leading-zero suppression, and tear-free value updates committed only at frame boundaries.
- Any nibble above 9 is blanked by the decoder, so this block forces 4'hF on the BCD output to darken segments.

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Display-scan bundle between the value source and the segment scanner.
// The master side supplies the digits and control; the slave side drives the
// shared BCD nibble, the anodes and the frame marker.
interface seg_scan_if;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output enable, load, value, lz_en,
        input  bcd_out, an, frame_done
    );

    modport slave (
        input  enable, load, value, lz_en,
        output bcd_out, an, frame_done
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Four-digit 7-segment scanner: one shared BCD nibble, active-low anodes,
// a dark lead-in at the start of every digit slot, optional leading-zero
// blanking, and display values swapped in only at frame boundaries.
//
// state | meaning
// IDLE  | display dark, counter and digit index held at 0
// BLANK | start of a slot, all anodes off while the nibble changes
// DRIVE | indexed digit lit until the slot ends
module seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] SLOT_PRELAST = CW'(REFRESH_DIV - 2);
    localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   active, shadow;
    logic          pending;
    logic          boundary;
    logic [3:0]    digit_nib;
    logic [3:0]    suppress;
    logic [3:0]    an_nxt, bcd_nxt;
    logic          frame_done_nxt;

    // Last DRIVE cycle of digit 3: the only point where a new value may take effect.
    assign boundary = (state == DRIVE) && (idx == 2'd3) && (cnt == SLOT_LAST);

    // State register with slot counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = 2'd0;
                if (bus.enable) state_nxt = BLANK;
            end
            BLANK: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == BLANK_LAST) state_nxt = DRIVE;
            end
            DRIVE: begin
                if (cnt == SLOT_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                    state_nxt = BLANK;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = 2'd0;
            end
        endcase
        if (!bus.enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = 2'd0;
        end
    end

    // Display value: immediate while dark, otherwise held in shadow until the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 16'h0000;
            shadow  <= 16'h0000;
            pending <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.load) begin
                active  <= bus.value;
                pending <= 1'b0;
            end
        end else if (boundary || !bus.enable) begin
            if (bus.load)    active <= bus.value;
            else if (pending) active <= shadow;
            pending <= 1'b0;
        end else if (bus.load) begin
            shadow  <= bus.value;
            pending <= 1'b1;
        end
    end

    // Leading-zero mask: a digit goes dark only if it and all digits above it are zero.
    always_comb begin
        suppress    = 4'b0000;
        suppress[3] = bus.lz_en && (active[15:12] == 4'h0);
        suppress[2] = suppress[3] && (active[11:8] == 4'h0);
        suppress[1] = suppress[2] && (active[7:4] == 4'h0);
        case (idx)
            2'd0:    digit_nib = active[3:0];
            2'd1:    digit_nib = active[7:4];
            2'd2:    digit_nib = active[11:8];
            default: digit_nib = active[15:12];
        endcase
    end

    // Output decode; frame_done is looked ahead one cycle so the pulse lines up with the commit cycle.
    always_comb begin
        an_nxt         = 4'hF;
        bcd_nxt        = 4'hF;
        frame_done_nxt = 1'b0;
        if (bus.enable && (state == DRIVE) && !suppress[idx]) begin
            an_nxt  = ~(4'b0001 << idx);
            bcd_nxt = digit_nib;
        end
        if (bus.enable && (state == DRIVE) && (idx == 2'd3) && (cnt == SLOT_PRELAST))
            frame_done_nxt = 1'b1;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an         <= 4'hF;
            bus.bcd_out    <= 4'hF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= an_nxt;
            bus.bcd_out    <= bcd_nxt;
            bus.frame_done <= frame_done_nxt;
        end
    end
endmodule
